// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
//
// Shared by uart_tx and uart_rx. Holds the transmit state encoding, the
// data width and the default clock/baud settings used by both halves.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int          UART_DATA_BITS   = 8;
  localparam logic [31:0] CLK_FREQ_DEFAULT = 32'd12_000_000;
  localparam logic [31:0] BAUDRATE_DEFAULT = 32'd9600;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period tick generator
//
// Counts 0..baud_cycles-1 and raises tick for one clock on the last count.
// A clear restarts the count, so the first tick lands exactly baud_cycles
// clocks after the clearing edge.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   clear  in  restart the bit period at this edge
//   tick   out one-cycle pulse marking the end of a bit period
module uart_baud_gen #(
  parameter int baud_cycles = 1250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (baud_cycles > 1) ? $clog2(baud_cycles) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(baud_cycles - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping on tick keeps every period exactly baud_cycles long, so the
  // bit boundaries never accumulate drift.
  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN)
//
// Serialises one byte per accepted request: start bit, 8 data bits LSB
// first, optional even-parity bit, stop bit. Optional feature macro:
// UART_TX_PARITY_EN inserts the parity bit and makes the frame 11 bits.
//
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   tx_start  in  send request, only looked at while idle
//   data_in   in  byte to send, latched on the accepting edge
//   tx_out    out serial line, idle high, registered
//   tx_busy   out high while a frame is in progress
//   tx_done   out one-cycle pulse at the end of the stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] clk_freq = CLK_FREQ_DEFAULT,
  parameter logic [31:0] baudrate = BAUDRATE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int baud_cycles = int'(clk_freq / baudrate);

  tx_state_t                 state;
  logic [UART_DATA_BITS-1:0] shift;
  logic [2:0]                bit_idx;
  logic                      tick;
  logic                      accept;
  logic                      clear;
`ifdef UART_TX_PARITY_EN
  logic                      parity;
`endif

  assign accept = (state == IDLE) && tx_start;
  // Restart the bit period on accept so the start bit is a full period.
  assign clear  = accept || tick;

  uart_baud_gen #(
    .baud_cycles(baud_cycles)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shift   <= data_in;
            bit_idx <= '0;
            state   <= START;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= ^data_in;
`endif
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            tx_out <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity;
`else
              state  <= STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              // Drive the next bit straight from shift[1] so tx_out changes
              // on the same edge as the shift.
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard testbench for uart_tx
module tb_uart_tx;

  localparam logic [31:0] CLK_FREQ = 32'd1_000_000;
  localparam logic [31:0] BAUD     = 32'd100_000;
  localparam int          BC       = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS    = 11;
`else
  localparam int          NBITS    = 10;
`endif
  localparam int          FRAME    = NBITS * BC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(
    .clk_freq(CLK_FREQ),
    .baudrate(BAUD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .data_in (data_in),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         e;
  } exp_t;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   free_at = 0;
  int   done_due = -1;
  int   exp_dones = 0;
  int   act_dones = 0;
  int   accepts = 0;
  int   last_e = -1;
  bit   mon_busy = 1'b0;
  exp_t exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a request is taken when the line has been free long enough;
  // the next one can only be taken one clock after the done edge.
  always @(posedge clk) begin
    exp_t ent;
    cyc++;
    if (reset) begin
      done_due = -1;
      free_at  = cyc + 1;
    end else begin
      if (cyc == done_due) begin
        exp_dones++;
        done_due = -1;
      end
      if (tx_start && cyc >= free_at) begin
        ent.d = data_in;
        ent.e = cyc;
        exp_q.push_back(ent);
        accepts++;
        last_e   = cyc;
        done_due = cyc + FRAME;
        free_at  = cyc + FRAME + 1;
      end
    end
  end

  always @(negedge clk) if (tx_done === 1'b1) act_dones++;

  function automatic logic exp_bit(int k, logic [7:0] d);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == NBITS - 1) return 1'b1;
    return ^d;
  endfunction

  task automatic check_frame(int s);
    exp_t e;
    int   busy_cnt = 0;
    int   done_at = -1;
    bit   aborted = 1'b0;
    mon_busy = 1'b1;
    check("frame_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.d = 8'h00;
      e.e = -1;
    end
    check("start_edge", s, e.e);
    for (int c = s; c <= s + FRAME; c++) begin
      if (c != s) @(negedge clk);
      if (reset) begin
        aborted = 1'b1;
        break;
      end
      if (c < s + FRAME && tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) done_at = c;
      for (int k = 0; k < NBITS; k++)
        if (c == s + k * BC + BC / 2)
          check($sformatf("bit%0d_of_%02h", k, e.d), tx_out, exp_bit(k, e.d));
    end
    if (!aborted) begin
      check("done_cycle", done_at - s, FRAME);
      check("busy_cycles", busy_cnt, FRAME);
      check("busy_low_at_done", tx_busy, 0);
    end
    mon_busy = 1'b0;
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b1;
      else if (prev === 1'b1 && tx_out === 1'b0) begin
        check_frame(cyc);
        prev = 1'b1;
      end else prev = tx_out;
    end
  end

  task automatic tick_drv();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(logic [7:0] d);
    tx_start = 1'b1;
    data_in  = d;
    tick_drv();
    tx_start = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc < free_at || mon_busy) && n < 4 * FRAME) begin
      tick_drv();
      n++;
    end
    check("idle_wait_bound", n < 4 * FRAME, 1);
  endtask

  task automatic wait_accepts(int target);
    int n = 0;
    while (accepts < target && n < 4 * FRAME) begin
      tick_drv();
      n++;
    end
    check("accept_wait_bound", accepts >= target, 1);
  endtask

  initial begin : stim
    int a0;
    int e1;
    repeat (5) tick_drv();
    reset = 1'b0;

    // Idle after reset: line high, nothing busy or done.
    repeat (30) begin
      @(negedge clk);
      check("idle_state", {tx_out, tx_busy, tx_done}, 3'b100);
    end
    tick_drv();

    pulse(8'h43);
    wait_idle();

    // Request during a frame is dropped, not queued.
    a0 = accepts;
    pulse(8'h70);
    repeat (4 * BC) tick_drv();
    pulse(8'hFF);
    wait_idle();
    check("busy_request_ignored", accepts - a0, 1);

    // Held request: two frames with one idle clock between them.
    a0 = accepts;
    tx_start = 1'b1;
    data_in  = 8'h55;
    wait_accepts(a0 + 1);
    e1 = last_e;
    data_in = 8'hAA;
    wait_accepts(a0 + 2);
    tx_start = 1'b0;
    check("back_to_back_spacing", last_e - e1, FRAME + 1);
    wait_idle();

    // Reset during data bit 3 abandons the frame.
    pulse(8'h39);
    repeat (4 * BC + 3) tick_drv();
    reset = 1'b1;
    tick_drv();
    reset = 1'b0;
    @(negedge clk);
    check("reset_tx_out", tx_out, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_done_count", act_dones, exp_dones);
    pulse(8'h39);
    wait_idle();

    // Random traffic, including requests landing on busy and done cycles.
    repeat (40) begin
      pulse(8'($urandom));
      repeat ($urandom_range(0, FRAME + 20)) begin
        if ($urandom_range(0, 9) == 0) pulse(8'($urandom));
        else tick_drv();
      end
    end
    wait_idle();

    repeat (5) tick_drv();
    check("done_pulse_count", act_dones, exp_dones);
    check("frames_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per request into an 8N1 frame on `tx_out`: start bit, 8 data bits LSB first, stop bit. With `UART_TX_PARITY_EN` defined, the frame is 8E1 instead. It is the transmit half of the UART transceiver and pairs with `uart_rx` on the same `clk_freq`/`baudrate` settings, so that a `tx_out`→`rx_in` loopback returns each byte unchanged.

## Interface
- `clk_freq`, default 32'd12_000_000, system clock frequency in Hz.
- `baudrate`, default 32'd9600, line rate in bit/s.
- `baud_cycles` (localparam) = `clk_freq / baudrate`, integer division (1250 at defaults); one bit period in clocks.
- `clk`  in  1  system clock, all logic on posedge.
- `reset`  in  1  reset; synchronous, active-high.
- `tx_start`  in  1  request to send `data_in`; sampled only when `tx_busy`=0.
- `data_in`  in  8  byte to send; latched on the accepting edge.
- `tx_out`  out  1  serial line; idle high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE: `tx_out`=1 and `tx_busy`=0. On `tx_start`=1, latch `data_in` into a shift register, clear the baud counter and bit index, and go to START.
- START: `tx_out`=0 for `baud_cycles` clocks, then go to DATA.
- DATA: `tx_out` = shift[0] for `baud_cycles` clocks per bit, then shift right. After bit index 7, go to PARITY if enabled, otherwise STOP.
- PARITY (macro only): `tx_out` = XOR of the latched byte (even parity) for `baud_cycles` clocks.
- STOP: `tx_out`=1 for `baud_cycles` clocks, then go to IDLE with `tx_done` pulsed.
- Baud counter runs 0..`baud_cycles`-1 and is cleared at every bit boundary. Width is `$clog2(baud_cycles)`. No cumulative drift.
- Bit index is 3 bits wide and used only in DATA.
- `tx_start` while busy is ignored. It is not queued.
- `data_in` changes after acceptance have no effect on the frame in flight.
- `tx_out` is driven from a flop, so the line is glitch-free.

## Timing
- Reset values: `tx_out`=1, `tx_busy`=0, `tx_done`=0; state IDLE, counters 0.
- Accept edge E: `tx_start`=1 and IDLE at posedge E. After E, `tx_out`=0 and `tx_busy`=1, with no idle cycle inserted.
- Bit k of the frame (k=0 is the start bit) occupies clocks [E + k·`baud_cycles`, E + (k+1)·`baud_cycles`).
- Frame length N is 10 bits, or 11 with parity.
- At edge E + N·`baud_cycles`:
  - state returns to IDLE, `tx_busy`=0, `tx_done`=1 for exactly that one cycle;
  - a `tx_start` sampled at this same edge is ignored, because `tx_busy` was still 1.
- Back-to-back: `tx_start` held or asserted during the `tx_done` cycle is accepted at the next edge. Gap between stop bit end and next start bit is 1 clock of idle-high.
- Reset mid-frame: at the next edge `tx_out`=1 and the FSM is IDLE. The truncated frame is abandoned and `tx_done` is not pulsed.
- Reset has priority over `tx_start` in the same cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in and an even-parity bit is inserted between data bit 7 and the stop bit;
  - frame is 11 bits and `tx_done` comes at E + 11·`baud_cycles`.
- Not defined: PARITY state and XOR logic are absent, and the frame is 8N1 with 10 bits.
- Ports are identical in both builds.

## Structure
- Shared package `uart_pkg`: `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP), `UART_DATA_BITS`=8, default `clk_freq`/`baudrate` constants. These are shared with `uart_rx`.
- Sub-module `uart_baud_gen` (parameter `baud_cycles`; ports `clk`, `reset`, `clear`, `tick`):
  - issues a one-cycle `tick` every `baud_cycles` clocks after `clear`;
  - `uart_tx` drives `clear` on accept and on bit boundaries.

## Test plan
- Reset 5 cycles, then idle 30 cycles → `tx_out`=1, `tx_busy`=0, `tx_done`=0 throughout.
- Send 0x43 → sampling mid-bit gives `tx_out` = 0,1,1,0,0,0,0,1,0,1. `tx_done` pulses exactly 12500 clocks after the accept edge, and `tx_busy` is high for exactly 12500 clocks.
- Send 0x70, then pulse `tx_start` with 0xFF at bit 4 → frame bits 0,0,0,0,0,1,1,1,0,1 are unchanged; 0xFF is never sent.
- Hold `tx_start`=1 with 0x55 then 0xAA → two frames separated by exactly 1 idle-high clock, each 12500 clocks long.
- Assert `reset` during data bit 3 of 0x39 → `tx_out`=1 at the next edge, `tx_busy`=0, no `tx_done`. The next request (0x39) is sent correctly.
- Loopback `tx_out`→`uart_rx.rx_in` sending 0x43, 0x70, 0x39 → `data_ready` pulses with `data_received` equal to each byte, `framing_error`=0.
- With `UART_TX_PARITY_EN`: send 0x43 → parity bit 1; `tx_done` at 13750 clocks.
